ads1115_sampler: RTL and testbench



---
 rtl/ads1115_sampler.sv | 151 +++++++++++++++
 tb/tb_ads1115_sampler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1115_sampler.sv
// Single-shot scan sequencer for an ADS1115 behind i2c_master: config write, conversion wait,
// pointer write, 2-byte read, then a one-cycle publish of the result per channel.
module ads1115_sampler #(
  parameter logic [6:0]  SLAVE_ADDR       = 7'h48,
  parameter int          NUM_CHANNELS     = 4,
  parameter logic [11:0] CONFIG_LOW       = 12'h3A3,
  parameter int          CONV_WAIT_CYCLES = 150000,
  parameter int          TIMEOUT_CYCLES   = 2000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        transaction_start,
  output logic        rd_nwr,
  output logic [6:0]  slave_addr,
  output logic [23:0] din,
  output logic [1:0]  transaction_bytes_num,
  input  logic [23:0] dout,
  input  logic        transaction_done,
  output logic [15:0] sample_data,
  output logic [1:0]  sample_channel,
  output logic        sample_valid,
  output logic        timeout_err
);

  localparam int WAIT_W = $clog2(CONV_WAIT_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] CONV_LAST = WAIT_W'(CONV_WAIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]        LAST_CH   = 2'(NUM_CHANNELS - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CFG_START = 4'd1,
    S_CFG_WAIT  = 4'd2,
    S_CONV_WAIT = 4'd3,
    S_PTR_START = 4'd4,
    S_PTR_WAIT  = 4'd5,
    S_RD_START  = 4'd6,
    S_RD_WAIT   = 4'd7,
    S_PUBLISH   = 4'd8
  } state_t;

  state_t             state_r;
  logic [1:0]         ch_r;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [15:0]        hold_r;

  // Low data byte is never part of a 2-byte read result.
  logic unused_dout_s;
  assign unused_dout_s = ^dout[7:0];

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r               <= S_IDLE;
      ch_r                  <= 2'd0;
      wait_cnt_r            <= {WAIT_W{1'b0}};
      tmo_cnt_r             <= {TMO_W{1'b0}};
      hold_r                <= 16'd0;
      transaction_start     <= 1'b0;
      rd_nwr                <= 1'b0;
      slave_addr            <= SLAVE_ADDR;
      din                   <= 24'd0;
      transaction_bytes_num <= 2'd0;
      sample_data           <= 16'd0;
      sample_channel        <= 2'd0;
      sample_valid          <= 1'b0;
      timeout_err           <= 1'b0;
    end else begin
      transaction_start <= 1'b0;
      sample_valid      <= 1'b0;
      timeout_err       <= 1'b0;
      slave_addr        <= SLAVE_ADDR;
      case (state_r)
        S_IDLE: begin
          if (enable) begin
            state_r <= S_CFG_START;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CFG_START: begin
          transaction_start     <= 1'b1;
          rd_nwr                <= 1'b0;
          transaction_bytes_num <= 2'd3;
          // OS=1 starts a conversion; mux 3'b100+ch selects single-ended input ch.
          din                   <= {8'h01, 1'b1, 1'b1, ch_r, CONFIG_LOW};
          tmo_cnt_r             <= {TMO_W{1'b0}};
          state_r               <= S_CFG_WAIT;
        end
        S_CONV_WAIT: begin
          if (wait_cnt_r == CONV_LAST) begin
            state_r <= S_PTR_START;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        S_PTR_START: begin
          transaction_start     <= 1'b1;
          rd_nwr                <= 1'b0;
          transaction_bytes_num <= 2'd1;
          din                   <= 24'h000000;
          tmo_cnt_r             <= {TMO_W{1'b0}};
          state_r               <= S_PTR_WAIT;
        end
        S_RD_START: begin
          transaction_start     <= 1'b1;
          rd_nwr                <= 1'b1;
          transaction_bytes_num <= 2'd2;
          tmo_cnt_r             <= {TMO_W{1'b0}};
          state_r               <= S_RD_WAIT;
        end
        S_CFG_WAIT, S_PTR_WAIT, S_RD_WAIT: begin
          // A done arriving on the last allowed cycle beats the timeout.
          if (transaction_done) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            case (state_r)
              S_CFG_WAIT: begin
                wait_cnt_r <= {WAIT_W{1'b0}};
                state_r    <= S_CONV_WAIT;
              end
              S_PTR_WAIT: state_r <= S_RD_START;
              S_RD_WAIT: begin
                hold_r  <= dout[23:8];
                state_r <= S_PUBLISH;
              end
              default: state_r <= S_IDLE;
            endcase
          end else if (tmo_cnt_r == TMO_LAST) begin
            timeout_err <= 1'b1;
            tmo_cnt_r   <= {TMO_W{1'b0}};
            state_r     <= S_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        S_PUBLISH: begin
          sample_data    <= hold_r;
          sample_channel <= ch_r;
          sample_valid   <= 1'b1;
          ch_r           <= (ch_r == LAST_CH) ? 2'd0 : ch_r + 2'd1;
          state_r        <= enable ? S_CFG_START : S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads1115_sampler.sv
// Randomised bench for ads1115_sampler: an i2c_master responder plus a transaction-level
// expectation model checked every cycle, with literal pins on the documented examples.
module tb_ads1115_sampler;

  localparam int NCH  = 4;
  localparam int CONV = 20;
  localparam int TMO  = 500;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        transaction_start, rd_nwr, transaction_done, sample_valid, timeout_err;
  logic [6:0]  slave_addr;
  logic [23:0] din, dout;
  logic [1:0]  transaction_bytes_num, sample_channel;
  logic [15:0] sample_data;

  int checks = 0;
  int errors = 0;

  ads1115_sampler #(
    .SLAVE_ADDR(7'h48), .NUM_CHANNELS(NCH), .CONFIG_LOW(12'h3A3),
    .CONV_WAIT_CYCLES(CONV), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .transaction_start(transaction_start), .rd_nwr(rd_nwr), .slave_addr(slave_addr),
    .din(din), .transaction_bytes_num(transaction_bytes_num), .dout(dout),
    .transaction_done(transaction_done), .sample_data(sample_data),
    .sample_channel(sample_channel), .sample_valid(sample_valid), .timeout_err(timeout_err)
  );

  always #4 clk = ~clk;

  function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  // i2c_master responder
  int          ack_delay   = 100;
  bit          rand_delay  = 1'b0;
  bit          no_ack      = 1'b0;
  bit          use_fixed   = 1'b1;
  bit          spurious_en = 1'b0;
  logic [23:0] fixed_dout  = 24'hA02900;

  initial begin
    bit busy;
    int rem;
    busy = 1'b0;
    rem = 0;
    transaction_done = 1'b0;
    dout = 24'd0;
    forever begin
      @(posedge clk);
      #1;
      transaction_done = 1'b0;
      dout = 24'($urandom);
      if (!reset_n) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          rem--;
          if (rem <= 0) begin
            busy = 1'b0;
            if (!no_ack) begin
              transaction_done = 1'b1;
              if (use_fixed) dout = fixed_dout;
            end
          end
        end
        if (transaction_start) begin
          busy = 1'b1;
          rem = rand_delay ? int'($urandom_range(120, 1)) : ack_delay;
        end else if (!busy && spurious_en && $urandom_range(15, 0) == 0) begin
          transaction_done = 1'b1;
        end
      end
    end
  end

  // Expectation model: which transaction comes next, and when publishes/timeouts are due.
  int          cyc = 0;
  int          exp_step = 0;
  int          exp_ch = 0;
  bit          outstanding = 1'b0;
  logic [23:0] o_din;
  logic        o_rd;
  logic [1:0]  o_bytes;
  int          cfg_done_cyc = 0;
  int          exp_valid_cyc = -1;
  int          exp_tmo_cyc = -1;
  logic [15:0] exp_data, pub_data = 16'd0;
  logic [1:0]  exp_chan, pub_chan = 2'd0;
  bit          prev_start = 1'b0;
  logic [7:0]  cfg_b1_q[$];

  always @(negedge clk) begin
    logic [23:0] e_din;
    logic        e_rd;
    logic [1:0]  e_bytes;
    cyc++;
    if (!reset_n) begin
      exp_step = 0; exp_ch = 0; outstanding = 1'b0; exp_valid_cyc = -1; exp_tmo_cyc = -1;
      pub_data = 16'd0; pub_chan = 2'd0; prev_start = 1'b0;
    end else begin
      check_eq("timeout_err", timeout_err, (cyc == exp_tmo_cyc));
      if (cyc == exp_tmo_cyc) begin
        outstanding = 1'b0; exp_step = 0; exp_tmo_cyc = -1;
      end
      check_eq("sample_valid", sample_valid, (cyc == exp_valid_cyc));
      if (cyc == exp_valid_cyc) begin
        pub_data = exp_data; pub_chan = exp_chan;
        exp_ch = (exp_ch + 1) % NCH; exp_step = 0; exp_valid_cyc = -1;
      end
      check_eq("sample_data", sample_data, pub_data);
      check_eq("sample_channel", sample_channel, pub_chan);
      check_eq("slave_addr", slave_addr, 7'h48);
      if (transaction_start) begin
        check_eq("start_width", prev_start, 1'b0);
        check_eq("start_unexpected", (outstanding || exp_step > 2), 1'b0);
        case (exp_step)
          0: begin
            e_din = {8'h01, 8'hC3 + 8'(16 * exp_ch), 8'hA3}; e_rd = 1'b0; e_bytes = 2'd3;
            cfg_b1_q.push_back(din[15:8]);
          end
          1: begin
            e_din = 24'h000000; e_rd = 1'b0; e_bytes = 2'd1;
            check_eq("conv_wait_gap", (cyc - cfg_done_cyc > CONV), 1'b1);
          end
          default: begin
            e_din = 24'h000000; e_rd = 1'b1; e_bytes = 2'd2;
          end
        endcase
        check_eq("req_din", din, e_din);
        check_eq("req_rd_nwr", rd_nwr, e_rd);
        check_eq("req_bytes", transaction_bytes_num, e_bytes);
        outstanding = 1'b1; o_din = e_din; o_rd = e_rd; o_bytes = e_bytes;
        exp_tmo_cyc = cyc + TMO;
      end else if (outstanding) begin
        check_eq("hold_din", din, o_din);
        check_eq("hold_rd_nwr", rd_nwr, o_rd);
        check_eq("hold_bytes", transaction_bytes_num, o_bytes);
      end
      if (transaction_done && outstanding && !transaction_start) begin
        outstanding = 1'b0; exp_tmo_cyc = -1;
        if (exp_step == 0) cfg_done_cyc = cyc;
        if (exp_step == 2) begin
          exp_valid_cyc = cyc + 2; exp_data = dout[23:8]; exp_chan = 2'(exp_ch);
        end
        exp_step++;
      end
      prev_start = transaction_start;
    end
  end

  // Bounded wait: 0 start, 1 sample_valid, 2 timeout_err, 3 transaction_done.
  task automatic wait_sig(input int which, input int budget, input string name);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = transaction_start;
        1: hit = sample_valid;
        2: hit = timeout_err;
        3: hit = transaction_done;
        default: hit = 1'b1;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start"}, transaction_start, 1'b0);
    check_eq({tag, "_rd_nwr"}, rd_nwr, 1'b0);
    check_eq({tag, "_din"}, din, 24'h0);
    check_eq({tag, "_bytes"}, transaction_bytes_num, 2'd0);
    check_eq({tag, "_sample_data"}, sample_data, 16'h0);
    check_eq({tag, "_sample_channel"}, sample_channel, 2'd0);
    check_eq({tag, "_sample_valid"}, sample_valid, 1'b0);
    check_eq({tag, "_timeout_err"}, timeout_err, 1'b0);
    check_eq({tag, "_slave_addr"}, slave_addr, 7'h48);
  endtask

  initial begin
    logic [7:0] exp_b1 [5];
    int starts;
    exp_b1 = '{8'hC3, 8'hD3, 8'hE3, 8'hF3, 8'hC3};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // First channel with a 100-cycle acknowledge and a fixed read value.
    enable = 1'b1;
    wait_sig(0, 10, "first_start");
    check_eq("first_din", din, 24'h01C3A3);
    check_eq("first_rd_nwr", rd_nwr, 1'b0);
    check_eq("first_bytes", transaction_bytes_num, 2'd3);
    @(negedge clk);
    check_eq("first_start_width", transaction_start, 1'b0);
    wait_sig(1, 1000, "first_sample");
    check_eq("first_sample_data", sample_data, 16'hA029);
    check_eq("first_sample_channel", sample_channel, 2'd0);

    // Random latencies, random data, stray done pulses outside wait states.
    use_fixed = 1'b0; rand_delay = 1'b1; spurious_en = 1'b1;
    for (int i = 0; i < 8; i++) wait_sig(1, 3000, "random_sample");
    check_eq("cfg_count", (cfg_b1_q.size() >= 5), 1'b1);
    for (int i = 0; i < 5 && i < cfg_b1_q.size(); i++) check_eq("cfg_byte1", cfg_b1_q[i], exp_b1[i]);

    // Silent i2c_master: timeout, then retry on the same channel with a 499-cycle ack.
    spurious_en = 1'b0; rand_delay = 1'b0; ack_delay = 30; no_ack = 1'b1;
    wait_sig(2, 2000, "timeout");
    no_ack = 1'b0; ack_delay = 499;
    wait_sig(1, 3000, "done_beats_timeout");
    ack_delay = 500;
    wait_sig(2, 1500, "timeout_at_limit");
    ack_delay = 40;
    wait_sig(1, 1000, "after_timeout");

    // Drop enable during the conversion wait.
    wait_sig(0, 20, "drop_cfg_start");
    wait_sig(3, 200, "drop_cfg_done");
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_sig(1, 1000, "drop_publish");
    starts = 0;
    repeat (300) begin
      @(negedge clk);
      if (transaction_start) starts++;
    end
    check_eq("idle_no_start", starts, 0);

    // Reset in the middle of a read.
    enable = 1'b1;
    wait_sig(0, 20, "rst_cfg_start");
    wait_sig(3, 200, "rst_cfg_done");
    wait_sig(0, 100, "rst_ptr_start");
    wait_sig(3, 200, "rst_ptr_done");
    wait_sig(0, 20, "rst_rd_start");
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_sig(1, 1000, "post_reset_sample");
    check_eq("post_reset_channel", sample_channel, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
